// File: rtl/sram_like_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sram_like_arbiter_pkg
// Shared definitions for the two-master SRAM-like arbiter:
//   - owner encodings stored in the response-routing queue
//   - SRAM-like transfer size encodings
//   - lock state encoding used by the top-level grant-hold FSM
// -----------------------------------------------------------------------------
package sram_like_arbiter_pkg;

    // Owner of an accepted request, as stored in the in-order queue.
    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    // SRAM-like size field encodings.
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Grant lock: which master (if any) holds an address phase that the
    // slave has seen but not yet accepted.
    typedef enum logic [1:0] {
        LK_NONE = 2'd0,
        LK_INST = 2'd1,
        LK_DATA = 2'd2
    } lock_state_e;

endpackage

// File: rtl/sram_like_arbiter_owner_fifo.sv
// -----------------------------------------------------------------------------
// sram_owner_fifo
// One-bit-wide in-order queue recording which master owns each accepted
// request. Read and write pointers wrap modulo DEPTH (power of two).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push_i          append push_own_i at the tail (caller guarantees !full_o)
//   push_own_i      owner bit to append (OWN_INST / OWN_DATA)
//   pop_i           remove the head (caller guarantees count_o != 0)
//   head_o          owner bit at the head
//   count_o         number of stored entries
//   full_o          count_o == DEPTH
// -----------------------------------------------------------------------------
module sram_owner_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             push_own_i,
    input  logic             pop_i,
    output logic             head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // Simultaneous push and pop leaves the count unchanged.
        if (push_i && !pop_i) begin
            count_d = count_q + 1'b1;
        end else if (!push_i && pop_i) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_own_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/sram_like_arbiter.sv
// -----------------------------------------------------------------------------
// sram_like_arbiter
// Two-master (inst fetch, load/store) to one-slave arbiter for the SRAM-like
// bus. Grants address phases (data port has priority), holds a grant until the
// slave accepts it, queues the owner of every accepted request and routes each
// returning data_ok to that owner in acceptance order.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   i_* / d_*                   inst / data master request fields and returns
//   s_*                         downstream slave request fields and returns
//   idle                        nothing outstanding and no grant lock held
//   err_spurious                sticky: s_data_ok arrived with empty queue
// Handshake: a request is transferred on a cycle where s_req && s_addr_ok;
// a response is consumed on every cycle where s_data_ok is high, with the
// matching x_data_ok asserted in that same cycle.
// -----------------------------------------------------------------------------
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = 4,
    parameter int CNT_W       = $clog2(OUTSTANDING) + 1
) (
    input  logic        clk,
    input  logic        rst,
    // inst master
    input  logic        i_req,
    input  logic        i_wr,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_addr,
    input  logic [3:0]  i_wstrb,
    input  logic [31:0] i_wdata,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    output logic [31:0] i_rdata,
    // data master
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_wstrb,
    input  logic [31:0] d_wdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [31:0] d_rdata,
    // slave
    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [31:0] s_addr,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_wdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,
    input  logic [31:0] s_rdata,
    // status
    output logic        idle,
    output logic        err_spurious
);

    lock_state_e      lock_q, lock_d;
    logic             err_spurious_q, err_spurious_d;

    logic             lock_hold;
    logic             sel_valid;
    logic             sel_own;
    logic             accept;
    logic             fifo_pop;
    logic             fifo_head;
    logic             fifo_full;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;

    assign fifo_empty = (fifo_count == '0);

    // Grant selection and lock next-state. A lock only holds while its owner
    // keeps requesting; if the owner drops req the lock is ignored and fresh
    // arbitration happens in the same cycle.
    always_comb begin
        lock_hold = ((lock_q == LK_INST) && i_req) ||
                    ((lock_q == LK_DATA) && d_req);
        sel_valid = 1'b0;
        sel_own   = OWN_INST;
        lock_d    = LK_NONE;

        if (lock_hold) begin
            sel_valid = 1'b1;
            sel_own   = (lock_q == LK_DATA) ? OWN_DATA : OWN_INST;
        end else if (d_req) begin
            sel_valid = 1'b1;
            sel_own   = OWN_DATA;
        end else if (i_req) begin
            sel_valid = 1'b1;
            sel_own   = OWN_INST;
        end

        // Full check uses the registered count: a pop this cycle does not
        // free a slot until the next one.
        s_req  = sel_valid && !fifo_full;
        accept = s_req && s_addr_ok;

        if (s_req && !s_addr_ok) begin
            lock_d = (sel_own == OWN_DATA) ? LK_DATA : LK_INST;
        end
    end

    // Request field mux; zero when nobody is selected.
    always_comb begin
        s_wr    = 1'b0;
        s_size  = 2'd0;
        s_addr  = 32'd0;
        s_wstrb = 4'd0;
        s_wdata = 32'd0;
        if (sel_valid) begin
            if (sel_own == OWN_DATA) begin
                s_wr    = d_wr;
                s_size  = d_size;
                s_addr  = d_addr;
                s_wstrb = d_wstrb;
                s_wdata = d_wdata;
            end else begin
                s_wr    = i_wr;
                s_size  = i_size;
                s_addr  = i_addr;
                s_wstrb = i_wstrb;
                s_wdata = i_wdata;
            end
        end
    end

    assign i_addr_ok = accept && (sel_own == OWN_INST);
    assign d_addr_ok = accept && (sel_own == OWN_DATA);

    // Response routing from the queue head; responses with nothing
    // outstanding are dropped and flagged.
    assign fifo_pop  = s_data_ok && !fifo_empty;
    assign i_data_ok = fifo_pop && (fifo_head == OWN_INST);
    assign d_data_ok = fifo_pop && (fifo_head == OWN_DATA);
    assign i_rdata   = s_rdata;
    assign d_rdata   = s_rdata;

    assign err_spurious_d = err_spurious_q || (s_data_ok && fifo_empty);

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q         <= LK_NONE;
            err_spurious_q <= 1'b0;
        end else begin
            lock_q         <= lock_d;
            err_spurious_q <= err_spurious_d;
        end
    end

    assign idle         = fifo_empty && (lock_q == LK_NONE);
    assign err_spurious = err_spurious_q;

    sram_owner_fifo #(
        .DEPTH (OUTSTANDING),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (accept),
        .push_own_i (sel_own),
        .pop_i      (fifo_pop),
        .head_o     (fifo_head),
        .count_o    (fifo_count),
        .full_o     (fifo_full)
    );

endmodule

// File: tb/tb_sram_like_arbiter.sv
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_wr, d_req, d_wr;
  logic [1:0]  i_size, d_size;
  logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
  logic [3:0]  i_wstrb, d_wstrb;
  logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
  logic [31:0] i_rdata, d_rdata;
  logic        s_req, s_wr;
  logic [1:0]  s_size;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_addr_ok, s_data_ok;
  logic [31:0] s_rdata;
  logic        idle, err_spurious;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram_like_arbiter #(.OUTSTANDING(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr),
    .i_wstrb(i_wstrb), .i_wdata(i_wdata),
    .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr),
    .d_wstrb(d_wstrb), .d_wdata(d_wdata),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr),
    .s_wstrb(s_wstrb), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .idle(idle), .err_spurious(err_spurious)
  );

  // ---------------- clock / reset helpers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    i_req = 0; i_wr = 0; i_size = 0; i_addr = 0; i_wstrb = 0; i_wdata = 0;
    d_req = 0; d_wr = 0; d_size = 0; d_addr = 0; d_wstrb = 0; d_wdata = 0;
    s_addr_ok = 0; s_data_ok = 0; s_rdata = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    next_cycle();
    next_cycle();
    rst = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    settle();
    total++; if (s_req !== 1'b0) begin bad++; $display("FAIL reset_s_req got=%b exp=0", s_req); end
    total++; if ({i_addr_ok, d_addr_ok, i_data_ok, d_data_ok} !== 4'b0) begin bad++; $display("FAIL reset_oks got=%b exp=0000", {i_addr_ok, d_addr_ok, i_data_ok, d_data_ok}); end
    total++; if (s_addr !== 32'd0 || s_wdata !== 32'd0) begin bad++; $display("FAIL reset_mux got=%h/%h exp=0/0", s_addr, s_wdata); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b exp=1", idle); end
    total++; if (err_spurious !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_spurious); end
  endtask

  task automatic test_priority();
    do_reset();
    i_req = 1; i_addr = 32'h1000; d_req = 1; d_addr = 32'h2000; s_addr_ok = 1;
    settle();
    total++; if ({d_addr_ok, i_addr_ok} !== 2'b10) begin bad++; $display("FAIL prio_c0 got d/i=%b exp=10", {d_addr_ok, i_addr_ok}); end
    total++; if (s_addr !== 32'h2000) begin bad++; $display("FAIL prio_c0_addr got=%h exp=2000", s_addr); end
    next_cycle();
    d_req = 0;
    settle();
    total++; if ({d_addr_ok, i_addr_ok} !== 2'b01) begin bad++; $display("FAIL prio_c1 got d/i=%b exp=01", {d_addr_ok, i_addr_ok}); end
    total++; if (s_addr !== 32'h1000) begin bad++; $display("FAIL prio_c1_addr got=%h exp=1000", s_addr); end
    next_cycle();
    i_req = 0; s_addr_ok = 0; s_data_ok = 1; s_rdata = 32'h11112222;
    settle();
    total++; if ({d_data_ok, i_data_ok} !== 2'b10) begin bad++; $display("FAIL prio_pop0 got d/i=%b exp=10", {d_data_ok, i_data_ok}); end
    total++; if (d_rdata !== 32'h11112222) begin bad++; $display("FAIL prio_rdata got=%h exp=11112222", d_rdata); end
    next_cycle();
    settle();
    total++; if ({d_data_ok, i_data_ok} !== 2'b01) begin bad++; $display("FAIL prio_pop1 got d/i=%b exp=01", {d_data_ok, i_data_ok}); end
    next_cycle();
    s_data_ok = 0;
    settle();
    total++; if (idle !== 1'b1 || err_spurious !== 1'b0) begin bad++; $display("FAIL prio_drained got idle/err=%b%b exp=10", idle, err_spurious); end
  endtask

  task automatic test_lock_hold();
    do_reset();
    i_req = 1; i_addr = 32'h100; s_addr_ok = 0;
    d_addr = 32'h200;
    for (int c = 0; c < 3; c++) begin
      if (c >= 1) d_req = 1;
      settle();
      total++; if (s_req !== 1'b1 || s_addr !== 32'h100) begin bad++; $display("FAIL lock_hold_c%0d got req=%b addr=%h exp req=1 addr=100", c, s_req, s_addr); end
      total++; if (d_addr_ok !== 1'b0 || i_addr_ok !== 1'b0) begin bad++; $display("FAIL lock_hold_ok_c%0d got d/i=%b%b exp=00", c, d_addr_ok, i_addr_ok); end
      if (c >= 1) begin
        total++; if (idle !== 1'b0) begin bad++; $display("FAIL lock_idle_c%0d got=%b exp=0", c, idle); end
      end
      next_cycle();
    end
    s_addr_ok = 1;
    settle();
    total++; if ({i_addr_ok, d_addr_ok} !== 2'b10) begin bad++; $display("FAIL lock_accept_c3 got i/d=%b exp=10", {i_addr_ok, d_addr_ok}); end
    next_cycle();
    i_req = 0;
    settle();
    total++; if (d_addr_ok !== 1'b1 || s_addr !== 32'h200) begin bad++; $display("FAIL lock_d_c4 got ok=%b addr=%h exp ok=1 addr=200", d_addr_ok, s_addr); end
    next_cycle();
    d_req = 0; s_addr_ok = 0; s_data_ok = 1;
    settle();
    total++; if ({i_data_ok, d_data_ok} !== 2'b10) begin bad++; $display("FAIL lock_pop0 got i/d=%b exp=10", {i_data_ok, d_data_ok}); end
    next_cycle();
    settle();
    total++; if ({i_data_ok, d_data_ok} !== 2'b01) begin bad++; $display("FAIL lock_pop1 got i/d=%b exp=01", {i_data_ok, d_data_ok}); end
    next_cycle();
    s_data_ok = 0;
  endtask

  task automatic test_lock_release();
    do_reset();
    i_req = 1; i_addr = 32'h300; d_addr = 32'h400; s_addr_ok = 0;
    next_cycle();
    next_cycle();
    i_req = 0; d_req = 1;
    settle();
    total++; if (s_req !== 1'b1 || s_addr !== 32'h400) begin bad++; $display("FAIL rel_switch got req=%b addr=%h exp req=1 addr=400", s_req, s_addr); end
    next_cycle();
    s_addr_ok = 1;
    settle();
    total++; if ({d_addr_ok, i_addr_ok} !== 2'b10) begin bad++; $display("FAIL rel_accept got d/i=%b exp=10", {d_addr_ok, i_addr_ok}); end
    next_cycle();
    d_req = 0; s_addr_ok = 0; s_data_ok = 1;
    settle();
    total++; if ({d_data_ok, i_data_ok} !== 2'b10) begin bad++; $display("FAIL rel_pop got d/i=%b exp=10", {d_data_ok, i_data_ok}); end
    next_cycle();
    s_data_ok = 0;
    settle();
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL rel_idle got=%b exp=1 (inst entry pushed?)", idle); end
  endtask

  task automatic test_full();
    do_reset();
    i_req = 1; i_addr = 32'h40; s_addr_ok = 1;
    for (int c = 0; c < 4; c++) begin
      settle();
      total++; if (i_addr_ok !== 1'b1) begin bad++; $display("FAIL full_push_c%0d got=%b exp=1", c, i_addr_ok); end
      next_cycle();
    end
    settle();
    total++; if (s_req !== 1'b0 || i_addr_ok !== 1'b0) begin bad++; $display("FAIL full_block got req/ok=%b%b exp=00", s_req, i_addr_ok); end
    total++; if (dut.u_fifo.count_o !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", dut.u_fifo.count_o); end
    s_data_ok = 1; s_rdata = 32'hDEADBEEF;
    settle();
    total++; if (i_data_ok !== 1'b1 || i_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL full_pop got ok=%b rdata=%h exp ok=1 rdata=deadbeef", i_data_ok, i_rdata); end
    total++; if (s_req !== 1'b0) begin bad++; $display("FAIL full_pop_block got=%b exp=0", s_req); end
    next_cycle();
    s_data_ok = 0;
    settle();
    total++; if (s_req !== 1'b1 || i_addr_ok !== 1'b1) begin bad++; $display("FAIL full_resume got req/ok=%b%b exp=11", s_req, i_addr_ok); end
    next_cycle();
    i_req = 0; s_addr_ok = 0; s_data_ok = 1;
    for (int c = 0; c < 4; c++) begin
      settle();
      total++; if (i_data_ok !== 1'b1) begin bad++; $display("FAIL full_drain_%0d got=%b exp=1", c, i_data_ok); end
      next_cycle();
    end
    s_data_ok = 0;
    settle();
    total++; if (idle !== 1'b1 || err_spurious !== 1'b0) begin bad++; $display("FAIL full_end got idle/err=%b%b exp=10", idle, err_spurious); end
  endtask

  task automatic test_order();
    logic [3:0] pat;
    do_reset();
    pat = 4'b0110; // bit k: owner of k-th accept (1=data): I,D,D,I
    s_addr_ok = 1;
    for (int k = 0; k < 4; k++) begin
      i_req = !pat[k]; d_req = pat[k];
      next_cycle();
    end
    i_req = 0; d_req = 0; s_addr_ok = 0; s_data_ok = 1;
    for (int k = 0; k < 4; k++) begin
      settle();
      total++; if ({d_data_ok, i_data_ok} !== {pat[k], !pat[k]}) begin bad++; $display("FAIL order_pop%0d got d/i=%b exp=%b", k, {d_data_ok, i_data_ok}, {pat[k], !pat[k]}); end
      next_cycle();
    end
    s_data_ok = 0;
    // count=2 [I,D], then push D while popping I
    s_addr_ok = 1; i_req = 1;
    next_cycle();
    i_req = 0; d_req = 1;
    next_cycle();
    s_data_ok = 1;
    settle();
    total++; if ({i_data_ok, d_addr_ok} !== 2'b11) begin bad++; $display("FAIL order_pushpop got idata/daddr=%b exp=11", {i_data_ok, d_addr_ok}); end
    next_cycle();
    d_req = 0; s_addr_ok = 0;
    settle();
    total++; if (dut.u_fifo.count_o !== 3'd2) begin bad++; $display("FAIL order_count got=%0d exp=2", dut.u_fifo.count_o); end
    for (int k = 0; k < 2; k++) begin
      total++; if ({d_data_ok, i_data_ok} !== 2'b10) begin bad++; $display("FAIL order_tail%0d got d/i=%b exp=10", k, {d_data_ok, i_data_ok}); end
      next_cycle();
      settle();
    end
    s_data_ok = 0;
  endtask

  task automatic test_spurious();
    do_reset();
    s_data_ok = 1; s_rdata = 32'h5A5A5A5A;
    settle();
    total++; if ({i_data_ok, d_data_ok} !== 2'b00) begin bad++; $display("FAIL spur_fwd got i/d=%b exp=00", {i_data_ok, d_data_ok}); end
    next_cycle();
    s_data_ok = 0;
    settle();
    total++; if (err_spurious !== 1'b1 || idle !== 1'b1) begin bad++; $display("FAIL spur_flag got err/idle=%b%b exp=11", err_spurious, idle); end
    next_cycle();
    next_cycle();
    total++; if (err_spurious !== 1'b1) begin bad++; $display("FAIL spur_sticky got=%b exp=1", err_spurious); end
    do_reset();
    settle();
    total++; if (err_spurious !== 1'b0) begin bad++; $display("FAIL spur_clear got=%b exp=0", err_spurious); end
  endtask

  // Randomized run against a queue-based reference of the arbitration rules.
  task automatic test_random();
    logic    exp_q[$];   // owners of accepted, unanswered requests (1=data)
    logic    m_lock;     // a grant is being held
    logic    m_lock_who; // holder of the grant (1=data)
    logic    sel_v, sel_w, e_sreq, e_acc;
    logic    e_iaok, e_daok, e_idok, e_ddok, e_idle;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wstrb;
    logic [1:0]  e_size;
    logic        e_wr;
    do_reset();
    m_lock = 0; m_lock_who = 0;
    for (int n = 0; n < 400; n++) begin
      i_req = ($urandom_range(0, 3) != 0); d_req = ($urandom_range(0, 2) == 0);
      i_wr = $urandom_range(0, 1); d_wr = $urandom_range(0, 1);
      i_size = 2'($urandom_range(0, 2)); d_size = 2'($urandom_range(0, 2));
      i_addr = $urandom; d_addr = $urandom; i_wdata = $urandom; d_wdata = $urandom;
      i_wstrb = 4'($urandom); d_wstrb = 4'($urandom);
      s_addr_ok = ($urandom_range(0, 2) != 0);
      s_data_ok = (exp_q.size() > 0) && ($urandom_range(0, 2) == 0);
      s_rdata = $urandom;

      if (m_lock && (m_lock_who ? d_req : i_req)) begin sel_v = 1; sel_w = m_lock_who; end
      else if (d_req) begin sel_v = 1; sel_w = 1; end
      else if (i_req) begin sel_v = 1; sel_w = 0; end
      else begin sel_v = 0; sel_w = 0; end
      e_sreq = sel_v && (exp_q.size() < 4);
      e_acc  = e_sreq && s_addr_ok;
      e_iaok = e_acc && !sel_w;
      e_daok = e_acc && sel_w;
      e_idok = s_data_ok && exp_q.size() > 0 && exp_q[0] == 1'b0;
      e_ddok = s_data_ok && exp_q.size() > 0 && exp_q[0] == 1'b1;
      e_idle = (exp_q.size() == 0) && !m_lock;
      e_wr    = !sel_v ? 1'b0  : (sel_w ? d_wr    : i_wr);
      e_size  = !sel_v ? 2'd0  : (sel_w ? d_size  : i_size);
      e_addr  = !sel_v ? 32'd0 : (sel_w ? d_addr  : i_addr);
      e_wstrb = !sel_v ? 4'd0  : (sel_w ? d_wstrb : i_wstrb);
      e_wdata = !sel_v ? 32'd0 : (sel_w ? d_wdata : i_wdata);

      settle();
      total++; if (s_req !== e_sreq) begin bad++; $display("FAIL rnd_s_req n=%0d got=%b exp=%b", n, s_req, e_sreq); end
      total++; if ({i_addr_ok, d_addr_ok} !== {e_iaok, e_daok}) begin bad++; $display("FAIL rnd_addr_ok n=%0d got=%b exp=%b", n, {i_addr_ok, d_addr_ok}, {e_iaok, e_daok}); end
      total++; if ({i_data_ok, d_data_ok} !== {e_idok, e_ddok}) begin bad++; $display("FAIL rnd_data_ok n=%0d got=%b exp=%b", n, {i_data_ok, d_data_ok}, {e_idok, e_ddok}); end
      total++; if ({s_wr, s_size, s_addr, s_wstrb, s_wdata} !== {e_wr, e_size, e_addr, e_wstrb, e_wdata}) begin bad++; $display("FAIL rnd_mux n=%0d got addr=%h exp addr=%h", n, s_addr, e_addr); end
      total++; if (i_rdata !== s_rdata || d_rdata !== s_rdata) begin bad++; $display("FAIL rnd_rdata n=%0d got=%h/%h exp=%h", n, i_rdata, d_rdata, s_rdata); end
      total++; if (idle !== e_idle) begin bad++; $display("FAIL rnd_idle n=%0d got=%b exp=%b", n, idle, e_idle); end

      if (e_idok || e_ddok) void'(exp_q.pop_front());
      if (e_acc) exp_q.push_back(sel_w);
      m_lock = e_sreq && !s_addr_ok;
      m_lock_who = sel_w;
      next_cycle();
    end
    total++; if (err_spurious !== 1'b0) begin bad++; $display("FAIL rnd_err got=%b exp=0", err_spurious); end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    test_reset();
    test_priority();
    test_lock_hold();
    test_lock_release();
    test_full();
    test_order();
    test_spurious();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
Two-master, one-slave arbiter for the SRAM-like bus. The instruction-fetch master (inst port) and the load/store master (data port) share a single downstream SRAM-like slave, normally the AXI bridge.
The block grants address phases, holds each grant until the slave accepts it, and records the owner of every accepted request in an in-order queue. It uses that queue to route each returning data_ok to the correct master.
Multiple requests may be outstanding, and the slave must return responses in acceptance order.

Parameters:
OUTSTANDING, 4, maximum accepted-but-unanswered requests (power of 2, >=2)
CNT_W, $clog2(OUTSTANDING)+1, width of the outstanding counter

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
i_req/i_wr  in  1/1  inst master request / write flag
i_size  in  2  transfer size (0=B, 1=H, 2=W)
i_addr/i_wdata  in  32/32  inst address / write data
i_wstrb  in  4  inst byte strobes
i_addr_ok/i_data_ok  out  1/1  inst address accepted / response valid
i_rdata  out  32  inst read data
d_req/d_wr/d_size/d_addr/d_wstrb/d_wdata  in  1/1/2/32/4/32  data master request fields, same meaning as the inst fields
d_addr_ok/d_data_ok  out  1/1  data master accept / response valid
d_rdata  out  32  data master read data
s_req/s_wr/s_size/s_addr/s_wstrb/s_wdata  out  1/1/2/32/4/32  slave request fields
s_addr_ok/s_data_ok  in  1/1  slave accept / response valid
s_rdata  in  32  slave read data
idle  out  1  no request outstanding and no lock held
err_spurious  out  1  sticky: s_data_ok arrived with an empty queue

Behaviour:
- Reset: queue empty, count=0, lock cleared, err_spurious=0. All combinational outputs then evaluate to 0 except idle=1.
- Arbitration is combinational each cycle:
  - If a lock is held, the locked owner is selected.
  - Otherwise the data port is selected if d_req=1, else the inst port if i_req=1.
- s_req = sel_req && (count != OUTSTANDING). A full queue blocks the grant even if s_data_ok pops an entry in the same cycle.
- The s_wr/s_size/s_addr/s_wstrb/s_wdata mux follows the selected owner. With no selection they are driven 0.
- Address accept:
  - x_addr_ok = s_req && s_addr_ok && (owner==x).
  - The other master's addr_ok is 0.
- Lock:
  - Set when s_req=1 and s_addr_ok=0; it records the owner.
  - Cleared on the accepting handshake.
  - Also cleared when the locked owner deasserts its req, which covers a fetch squashed by a branch or flush. Arbitration then restarts that cycle.
  - While the lock is held, the other master waits even if it is the data port.
- Queue push: on s_req && s_addr_ok, the owner bit is pushed (0=inst, 1=data). Write requests are pushed too and receive a data_ok.
- Queue pop: on s_data_ok with count>0, the head is popped.
  - x_data_ok = s_data_ok && count>0 && head==x.
  - s_rdata is broadcast to both i_rdata and d_rdata unmodified.
- Simultaneous push and pop: count stays the same, and both pointers advance with wrap modulo OUTSTANDING.
- A response is passed through in the same cycle it arrives (zero latency). An accepted request appears on the queue tail the next cycle.
- Spurious response: s_data_ok with count==0 is not forwarded. Pointers and count are unchanged and err_spurious is set until rst.
- idle = (count==0) && !lock. The IF/MEM stages use it to decide when cancelled responses have drained.
- Reset mid-operation clears everything. Responses still in flight from before rst show up as spurious and set err_spurious; the slave must be reset together with the arbiter.

Decomposition:
- Shared package: OWN_INST=1'b0 and OWN_DATA=1'b1 constants; the SRAM-like size encodings SZ_B/SZ_H/SZ_W.
- One sub-module, sram_owner_fifo: 1-bit wide, depth OUTSTANDING. It has push, pop, head, count and full outputs, and wraps its read and write pointers.
- Arbitration, lock and muxing stay in the top module.

Test Plan:
- i_req and d_req high at once, s_addr_ok=1 -> d_addr_ok=1 and i_addr_ok=0 in cycle 0. The inst request is granted in cycle 1, and the queue holds [D,I].
- i_req with s_addr_ok=0 for 3 cycles, d_req rising in cycle 1 -> s_addr stays the inst address and d_addr_ok stays 0. i_addr_ok=1 in cycle 3, and the data request is granted in cycle 4.
- Lock held for inst, then i_req dropped in cycle 2 with d_req=1 -> lock clears, s_req switches to the data address in cycle 2, and nothing is pushed for inst.
- Push 4 inst reads without any s_data_ok -> count=4 and s_req=0 in cycle 4 despite i_req=1. Then s_data_ok with s_rdata=0xDEADBEEF -> i_data_ok=1, i_rdata=0xDEADBEEF, and s_req returns next cycle.
- Interleaved order I,D,D,I accepted, then four s_data_ok pulses -> data_ok sequence inst,data,data,inst. A same-cycle push and pop at count=2 keeps count=2.
- s_data_ok at reset-idle -> no x_data_ok, err_spurious=1, idle=1; a later rst clears err_spurious to 0.
